// File: rtl/pic_ctrl_pkg.sv
// rtl/pic_ctrl_pkg.sv - shared state encoding and command bytes for the picture controller.
package pic_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SEND_RD   = 3'd2,
    ST_SEND_WAIT = 3'd3,
    ST_SEND_TX   = 3'd4,
    ST_CSUM_TX   = 3'd5
  } pic_state_t;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_SEND = 8'h53;

endpackage

// File: rtl/uart_picture_ctrl.sv
// rtl/uart_picture_ctrl.sv - UART byte-stream peer that loads/streams a picture to/from image RAM.
// Optional trailing XOR checksum byte after each load/send is enabled with PIC_CHECKSUM_EN.
module uart_picture_ctrl
  import pic_ctrl_pkg::*;
#(
  parameter int         P_IMG_BYTES = 101376,
  parameter logic [7:0] P_CMD_LOAD  = CMD_LOAD,
  parameter logic [7:0] P_CMD_SEND  = CMD_SEND,
  localparam int        AW          = $clog2(P_IMG_BYTES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_stb,
  output logic [7:0]    tx_data,
  output logic          tx_stb,
  input  logic          tx_ack,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic          busy,
  output logic          load_done,
  output logic          send_done
);

  localparam logic [AW-1:0] LAST = AW'(P_IMG_BYTES - 1);

  pic_state_t    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_stb_q, tx_stb_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_we_q, mem_we_d;
  logic [7:0]    mem_wdata_q, mem_wdata_d;
  logic          load_done_q, load_done_d;
  logic          send_done_q, send_done_d;
`ifdef PIC_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  // The UART pulses ack once after reset with nothing offered; only honour ack for a live byte.
  logic ack_v;
  assign ack_v = tx_ack & tx_stb_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_data_d   = tx_data_q;
    tx_stb_d    = tx_stb_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    load_done_d = 1'b0;
    send_done_d = 1'b0;
`ifdef PIC_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (rx_stb && rx_data == P_CMD_LOAD) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
`ifdef PIC_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
        end else if (rx_stb && rx_data == P_CMD_SEND) begin
          // Present address 0 now so read data is ready by the end of SEND_WAIT.
          state_d    = ST_SEND_RD;
          cnt_d      = '0;
          mem_addr_d = '0;
`ifdef PIC_CHECKSUM_EN
          csum_d     = 8'h00;
`endif
        end
      end
      ST_LOAD: begin
        if (rx_stb) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt_q;
          mem_wdata_d = rx_data;
`ifdef PIC_CHECKSUM_EN
          csum_d      = csum_q ^ rx_data;
`endif
          if (cnt_q == LAST) begin
            load_done_d = 1'b1;
`ifdef PIC_CHECKSUM_EN
            state_d   = ST_CSUM_TX;
            tx_data_d = csum_q ^ rx_data;
            tx_stb_d  = 1'b1;
`else
            state_d   = ST_IDLE;
`endif
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      ST_SEND_RD: begin
        mem_addr_d = cnt_q;
        state_d    = ST_SEND_WAIT;
      end
      ST_SEND_WAIT: begin
        tx_data_d = mem_rdata;
        tx_stb_d  = 1'b1;
        state_d   = ST_SEND_TX;
      end
      ST_SEND_TX: begin
        if (ack_v) begin
          tx_stb_d = 1'b0;
`ifdef PIC_CHECKSUM_EN
          csum_d   = csum_q ^ tx_data_q;
`endif
          if (cnt_q == LAST) begin
            send_done_d = 1'b1;
`ifdef PIC_CHECKSUM_EN
            state_d   = ST_CSUM_TX;
            tx_data_d = csum_q ^ tx_data_q;
            tx_stb_d  = 1'b1;
`else
            state_d   = ST_IDLE;
`endif
          end else begin
            cnt_d      = cnt_q + AW'(1);
            mem_addr_d = cnt_q + AW'(1);
            state_d    = ST_SEND_RD;
          end
        end
      end
`ifdef PIC_CHECKSUM_EN
      ST_CSUM_TX: begin
        if (ack_v) begin
          tx_stb_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tx_data_q   <= 8'h00;
      tx_stb_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 8'h00;
      load_done_q <= 1'b0;
      send_done_q <= 1'b0;
`ifdef PIC_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_data_q   <= tx_data_d;
      tx_stb_q    <= tx_stb_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      load_done_q <= load_done_d;
      send_done_q <= send_done_d;
`ifdef PIC_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_stb    = tx_stb_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign load_done = load_done_q;
  assign send_done = send_done_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_picture_ctrl.sv
// tb/tb_uart_picture_ctrl.sv - directed-vector bench for uart_picture_ctrl with a 4-byte picture.
module tb_uart_picture_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_stb;
  logic [7:0] tx_data;
  logic       tx_stb;
  logic       tx_ack;
  logic [1:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       load_done;
  logic       send_done;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] ram [0:3];
  logic       tx_ack_m, ack_force, ack_en;
  int         ack_cnt;

  int wr_addr_q[$];
  int wr_data_q[$];
  int tx_q[$];
  int ld_cnt, sd_cnt, sd_txn, ld_with_we;

  always #5 clk = ~clk;

  uart_picture_ctrl #(.P_IMG_BYTES(4)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_stb(rx_stb),
    .tx_data(tx_data), .tx_stb(tx_stb), .tx_ack(tx_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .load_done(load_done), .send_done(send_done)
  );

  // 1-clk-latency RAM model
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  assign tx_ack = tx_ack_m | ack_force;

  // Ack model: one-clk pulse 10 clk after tx_stb is seen
  initial begin
    tx_ack_m = 1'b0;
    ack_cnt  = 0;
    forever begin
      @(negedge clk);
      tx_ack_m = 1'b0;
      if (rst || !tx_stb || !ack_en) ack_cnt = 0;
      else begin
        ack_cnt++;
        if (ack_cnt == 10) begin
          tx_ack_m = 1'b1;
          ack_cnt  = 0;
        end
      end
    end
  end

  initial begin
    ld_cnt = 0; sd_cnt = 0; sd_txn = 0; ld_with_we = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (mem_we) begin
          wr_addr_q.push_back(int'(mem_addr));
          wr_data_q.push_back(int'(mem_wdata));
        end
        if (tx_stb && tx_ack) tx_q.push_back(int'(tx_data));
        if (load_done) begin
          ld_cnt++;
          if (mem_we && mem_addr == 2'd3) ld_with_we++;
        end
        if (send_done) begin
          sd_cnt++;
          sd_txn = tx_q.size();
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr_q.delete(); wr_data_q.delete(); tx_q.delete();
    ld_cnt = 0; sd_cnt = 0; sd_txn = 0; ld_with_we = 0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_stb  = 1'b1;
    @(negedge clk);
    rx_stb  = 1'b0;
    rx_data = 8'h00;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_tx_stb(input string tag);
    int n = 0;
    while (!tx_stb && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, tx_stb}, 32'd1);
  endtask

  task automatic check_writes(input string tag, input int a[4], input int d[4]);
    check({tag, "_nwr"}, wr_addr_q.size(), 4);
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], a[i]);
      check($sformatf("%s_data%0d", tag, i), wr_data_q[i], d[i]);
    end
  endtask

  task automatic check_tx(input string tag, input int exp[$]);
    check({tag, "_ntx"}, tx_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < tx_q.size(); i++)
      check($sformatf("%s_tx%0d", tag, i), tx_q[i], exp[i]);
  endtask

  initial begin
    int addrs[4];
    int exp_tx[$];
    addrs = '{0, 1, 2, 3};
    for (int i = 0; i < 4; i++) ram[i] = 8'h00;
    rst = 1'b1; rx_data = 8'h00; rx_stb = 1'b0; ack_force = 1'b0; ack_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_stb", {31'd0, tx_stb}, 0);
    check("rst_tx_data", {24'd0, tx_data}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_mem_we", {31'd0, mem_we}, 0);
    check("rst_mem_addr", {30'd0, mem_addr}, 0);
    check("rst_dones", {30'd0, load_done, send_done}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1: reset in the middle of SEND_TX
    send_rx(8'h53);
    wait_tx_stb("t1_stb_up");
    check("t1_busy_up", {31'd0, busy}, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t1_rst_stb", {31'd0, tx_stb}, 0);
    check("t1_rst_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    ack_en = 1'b1;
    repeat (15) @(negedge clk);
    check("t1_no_stb_after", {31'd0, tx_stb}, 0);
    clear_log();

    // 2: load 11,22,33,44
    send_rx(8'h4C);
    send_rx(8'h11); send_rx(8'h22); send_rx(8'h33); send_rx(8'h44);
    wait_idle("t2_idle");
    check_writes("t2", addrs, '{'h11, 'h22, 'h33, 'h44});
    check("t2_ld_cnt", ld_cnt, 1);
    check("t2_ld_with_last_we", ld_with_we, 1);
`ifdef PIC_CHECKSUM_EN
    exp_tx = '{'h44};
`else
    exp_tx = '{};
`endif
    check_tx("t2", exp_tx);
    clear_log();

    // 3: send back, restarting from address 0
    send_rx(8'h53);
    wait_idle("t3_idle");
`ifdef PIC_CHECKSUM_EN
    exp_tx = '{'h11, 'h22, 'h33, 'h44, 'h44};
`else
    exp_tx = '{'h11, 'h22, 'h33, 'h44};
`endif
    check_tx("t3", exp_tx);
    check("t3_sd_cnt", sd_cnt, 1);
    check("t3_sd_at_4th", sd_txn, 4);
    check("t3_no_writes", wr_addr_q.size(), 0);
    clear_log();

    // 4: junk ignored in IDLE, command bytes are data inside LOAD
    send_rx(8'h00);
    check("t4_busy_00", {31'd0, busy}, 0);
    send_rx(8'hFF);
    check("t4_busy_ff", {31'd0, busy}, 0);
    send_rx(8'h4C);
    send_rx(8'h4C); send_rx(8'hAA); send_rx(8'h53); send_rx(8'h01);
    wait_idle("t4_idle");
    check_writes("t4", addrs, '{'h4C, 'hAA, 'h53, 'h01});
    check("t4_ld_cnt", ld_cnt, 1);
    clear_log();

    // 5: stray ack in IDLE, rx during SEND
    @(negedge clk);
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    @(negedge clk);
    check("t5_ack_idle_busy", {31'd0, busy}, 0);
    check("t5_ack_idle_stb", {31'd0, tx_stb}, 0);
    ack_en = 1'b0;
    send_rx(8'h53);
    wait_tx_stb("t5_stb_up");
    send_rx(8'h4C);
    send_rx(8'h99);
    check("t5_rx_send_busy", {31'd0, busy}, 1);
    check("t5_rx_send_stb", {31'd0, tx_stb}, 1);
    check("t5_rx_send_data", {24'd0, tx_data}, 32'h4C);
    check("t5_rx_send_nowr", wr_addr_q.size(), 0);
    ack_en = 1'b1;
    wait_idle("t5_idle");
`ifdef PIC_CHECKSUM_EN
    exp_tx = '{'h4C, 'hAA, 'h53, 'h01, 'hB4};
`else
    exp_tx = '{'h4C, 'hAA, 'h53, 'h01};
`endif
    check_tx("t5", exp_tx);
    check("t5_sd_cnt", sd_cnt, 1);
    check("t5_nowr_end", wr_addr_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
